// File: rtl/tinymem_lsu_pkg.sv
// Shared types for the tinymem load/store unit: access sizes, LSU states and
// the alignment helper used when TINYMEM_LSU_MISALIGN_CHECK_EN is defined.
package tinymem_lsu_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_SIZE_BYTE = 2'd0,
    MEM_ACCESS_SIZE_HALF = 2'd1,
    MEM_ACCESS_SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_t;

  function automatic logic is_misaligned(input mem_access_size_t size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_ACCESS_SIZE_HALF: mis = addr_lo[0];
      MEM_ACCESS_SIZE_WORD: mis = (addr_lo != 2'd0);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/tinymemif.sv
// Single-port style memory bus between an initiator and a memory/cache slave.
interface tinymemif;
  import tinymem_lsu_pkg::*;

  logic [31:0]      rd_addr;
  mem_access_size_t rd_size;
  logic [31:0]      rd_data;
  logic [31:0]      wr_addr;
  mem_access_size_t wr_size;
  logic [31:0]      wr_data;
  logic             wr_enable;
  logic             busy;

  modport master (
    output rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
    input  rd_data, busy
  );

  modport slave (
    input  rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
    output rd_data, busy
  );

endinterface

// File: rtl/tinymem_lsu_load_extend.sv
// Combinational load-data extraction: picks the low byte/half/word of the
// bus data and sign- or zero-extends it to 32 bits.
module lsu_load_extend
  import tinymem_lsu_pkg::*;
(
  input  logic [31:0] rd_data,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  // Size-dependent extension; WORD passes through so the signed flag has no effect
  always_comb begin
    result = rd_data;
    case (mem_access_size_t'(size))
      MEM_ACCESS_SIZE_BYTE: result = {{24{is_signed & rd_data[7]}}, rd_data[7:0]};
      MEM_ACCESS_SIZE_HALF: result = {{16{is_signed & rd_data[15]}}, rd_data[15:0]};
      MEM_ACCESS_SIZE_WORD: result = rd_data;
      default:              result = rd_data;
    endcase
  end

endmodule

// File: rtl/tinymem_lsu.sv
// Load/store initiator for tinymemif: one request at a time, busy-aware, with
// busy timeout. Define TINYMEM_LSU_MISALIGN_CHECK_EN to reject misaligned accesses.
module tinymem_lsu
  import tinymem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_write_i,
  input  logic [31:0]  req_addr_i,
  input  logic [1:0]   req_size_i,
  input  logic         req_signed_i,
  input  logic [31:0]  req_wdata_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output logic [31:0]  resp_data_o,
  output logic         resp_error_o,
  tinymemif.master     memif
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);

  lsu_state_t       state_r;
  logic             write_r;
  logic             signed_r;
  logic [CNT_W-1:0] busy_cnt_r;
  logic [31:0]      ext_s;
  logic             misalign_s;

`ifdef TINYMEM_LSU_MISALIGN_CHECK_EN
  assign misalign_s = is_misaligned(mem_access_size_t'(req_size_i), req_addr_i[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign req_ready_o = (state_r == LSU_IDLE);

  lsu_load_extend u_ext (
    .rd_data   (memif.rd_data),
    .size      (memif.rd_size),
    .is_signed (signed_r),
    .result    (ext_s)
  );

  // Request sequencing; the memif outputs double as the request address/size/data registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r         <= LSU_IDLE;
      write_r         <= 1'b0;
      signed_r        <= 1'b0;
      busy_cnt_r      <= '0;
      resp_valid_o    <= 1'b0;
      resp_data_o     <= 32'd0;
      resp_error_o    <= 1'b0;
      memif.rd_addr   <= 32'd0;
      memif.rd_size   <= MEM_ACCESS_SIZE_BYTE;
      memif.wr_addr   <= 32'd0;
      memif.wr_size   <= MEM_ACCESS_SIZE_BYTE;
      memif.wr_data   <= 32'd0;
      memif.wr_enable <= 1'b0;
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (req_valid_i) begin
            write_r    <= req_write_i;
            signed_r   <= req_signed_i;
            busy_cnt_r <= '0;
            if (misalign_s) begin
              state_r      <= LSU_RESP;
              resp_valid_o <= 1'b1;
              resp_error_o <= 1'b1;
              resp_data_o  <= 32'd0;
            end else begin
              state_r <= LSU_ACCESS;
              if (req_write_i) begin
                memif.wr_addr   <= req_addr_i;
                memif.wr_size   <= mem_access_size_t'(req_size_i);
                memif.wr_data   <= req_wdata_i;
                memif.wr_enable <= 1'b1;
              end else begin
                memif.rd_addr <= req_addr_i;
                memif.rd_size <= mem_access_size_t'(req_size_i);
              end
            end
          end
        end
        LSU_ACCESS: begin
          if (!memif.busy) begin
            state_r         <= LSU_RESP;
            memif.wr_enable <= 1'b0;
            resp_valid_o    <= 1'b1;
            resp_error_o    <= 1'b0;
            resp_data_o     <= write_r ? 32'd0 : ext_s;
          end else if ((TIMEOUT_CYCLES != 32'd0) && (busy_cnt_r == TO_LAST)) begin
            state_r         <= LSU_RESP;
            busy_cnt_r      <= busy_cnt_r + CNT_W'(1);
            memif.wr_enable <= 1'b0;
            resp_valid_o    <= 1'b1;
            resp_error_o    <= 1'b1;
            resp_data_o     <= 32'd0;
          end else begin
            busy_cnt_r <= busy_cnt_r + CNT_W'(1);
          end
        end
        LSU_RESP: begin
          if (resp_ready_i) begin
            state_r      <= LSU_IDLE;
            resp_valid_o <= 1'b0;
          end
        end
        default: begin
          state_r         <= LSU_IDLE;
          memif.wr_enable <= 1'b0;
          resp_valid_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
